ulpi_reg_seq: RTL and testbench
===============================

ULPI_REG_SEQ -- requirements
Module: ulpi_reg_seq

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, giving the number of re-issues allowed after a failed access.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, giving the wait-for-response limit in cycles.
REQ-003 CLK_60M  in  1  60 MHz ULPI clock; the only clock.
REQ-004 RST_A_USB  in  1  reset, asynchronous, active-high.
REQ-005 U_READY  in  1  ULPI register port ready; 0 while the PHY link is in reset.
REQ-006 U_REG_DONE / U_REG_FAIL  in  1 each  one-cycle completion / abort pulses.
REQ-007 U_REG_DATA_O  in  8  read data, valid in the U_REG_DONE cycle.
REQ-008 U_REG_EN  out  1  access strobe; U_REG_RW  out  1  (1=write, 0=read).
REQ-009 U_REG_ADDR  out  6, and U_REG_DATA_I  out  8: register address and write data.
REQ-010 R0_REQ, R1_REQ  in  1  requester access request, held until ACK or ERR.
REQ-011 Rn_RW  in  1, Rn_ADDR  in  6, Rn_WDATA  in  8: per-requester access fields, stable while Rn_REQ=1.
REQ-012 R0_ACK, R1_ACK, R0_ERR, R1_ERR  out  1  one-cycle completion / failure pulses.
REQ-013 RDATA  out  8  last read data, shared by both requesters.
REQ-014 INIT_DONE  out  1, and INIT_ERR  out  1: boot table finished / a boot entry exhausted its retries.

Function
REQ-015 States: BOOT, I_ISSUE, I_WAIT, ARB, ISSUE, WAIT, RESP.
REQ-016 BOOT: entry index=0 and INIT_DONE=0; go to I_ISSUE on the first cycle with U_READY=1.
REQ-017 Boot table, issued as writes in order:
- (0x0A, 0x00) OTG Control
- (0x04, 0x45) Function Control: FS, TermSelect, SuspendM
- (0x07, 0x00) Interface Control
REQ-018 I_ISSUE/ISSUE: assert U_REG_EN for exactly one cycle with RW/ADDR/DATA_I valid, then go to the matching WAIT state next cycle.
REQ-019 U_REG_RW, U_REG_ADDR and U_REG_DATA_I SHALL hold their values from issue until the response; they are 0 when no access is active.
REQ-020 WAIT states: an 8-bit timeout counter, cleared at issue, increments each cycle; counter==TIMEOUT is treated as U_REG_FAIL.
REQ-021 On U_REG_DONE:
- read: capture U_REG_DATA_O into RDATA
- clear the retry count
- boot: advance to the next entry, or after the last entry set INIT_DONE=1 and go to ARB
- normal: go to RESP
REQ-022 On fail with retry count < MAX_RETRY: increment the retry count and return to the matching ISSUE state; the re-issue strobe occurs 2 cycles after the fail pulse.
REQ-023 On fail with retry count == MAX_RETRY:
- boot: set INIT_ERR=1 (sticky until reset), skip to the next entry
- normal: go to RESP with the error flag set
REQ-024 ARB: when exactly one requester has REQ=1, grant it; go to ISSUE next cycle.
REQ-025 ARB, both requesting: round-robin; grant the requester not granted last (R0 after reset), and update the last-grant register at the grant.
REQ-026 RESP: pulse Rn_ACK (success) or Rn_ERR (fail) of the granted requester for one cycle, then go to ARB.
REQ-027 Access latency: ARB grant → U_REG_EN at +1 cycle; U_REG_DONE at cycle t → Rn_ACK at t+1, with RDATA valid from t+1 until the next read completes.
REQ-028 Requests are never accepted while INIT_DONE=0; requester inputs are ignored outside ARB.
REQ-029 U_READY=0 in any state other than BOOT:
- abort the current access
- pulse ERR of the granted requester, if any, in the next cycle
- clear INIT_DONE, return to BOOT and re-run the full table
REQ-030 U_REG_DONE and U_REG_FAIL arriving in the same cycle: DONE wins.
REQ-031 DONE/FAIL pulses received outside a WAIT state are ignored.

Reset
REQ-032 RST_A_USB=1 SHALL immediately force all of the following to 0:
- state=BOOT, entry index, retry count, timeout counter, last-grant register
- RDATA, INIT_DONE, INIT_ERR
- every output
REQ-033 Reset asserted mid-access SHALL drop U_REG_EN and ACK/ERR combinationally-free: all are registered and cleared asynchronously.
REQ-034 After reset release, the boot table SHALL re-run from entry 0.

Verification
REQ-035 Boot: U_READY=1 and DONE 4 cycles after each EN → three writes (0x0A,00),(0x04,45),(0x07,00) in order, then INIT_DONE=1 and INIT_ERR=0.
REQ-036 Retry: FAIL on the first two issues of entry 0x04 → exactly 3 EN pulses for 0x04, INIT_ERR=0; FAIL on all 4 issues → INIT_ERR=1, then entry 0x07 is issued.
REQ-037 Arbitration: R0 and R1 request continuously after INIT_DONE → grants alternate R0,R1,R0,R1; each gets ACK 1 cycle after its DONE.
REQ-038 Read and timeout:
- R1 read of 0x00 with DONE and U_REG_DATA_O=0x24 → RDATA=0x24 with R1_ACK
- no response at all → R1_ERR after 4×256 cycles of waiting
REQ-039 Reset and link loss:
- RST_A_USB pulsed while in WAIT → all outputs 0 immediately; boot restarts at 0x0A
- U_READY drop during an R0 access → R0_ERR pulse, INIT_DONE=0, table re-run

Source files
------------

// File: rtl/ulpi_reg_seq.sv
`timescale 1ns/1ps
// ULPI register-access sequencer: runs a PHY boot table after link-up, then
// arbitrates two requesters onto the single ULPI register port with retry/timeout.
module ulpi_reg_seq #(
  parameter int         MAX_RETRY = 3,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic       CLK_60M,
  input  logic       RST_A_USB,
  input  logic       U_READY,
  input  logic       U_REG_DONE,
  input  logic       U_REG_FAIL,
  input  logic [7:0] U_REG_DATA_O,
  output logic       U_REG_EN,
  output logic       U_REG_RW,
  output logic [5:0] U_REG_ADDR,
  output logic [7:0] U_REG_DATA_I,
  input  logic       R0_REQ,
  input  logic       R0_RW,
  input  logic [5:0] R0_ADDR,
  input  logic [7:0] R0_WDATA,
  input  logic       R1_REQ,
  input  logic       R1_RW,
  input  logic [5:0] R1_ADDR,
  input  logic [7:0] R1_WDATA,
  output logic       R0_ACK,
  output logic       R1_ACK,
  output logic       R0_ERR,
  output logic       R1_ERR,
  output logic [7:0] RDATA,
  output logic       INIT_DONE,
  output logic       INIT_ERR
);

  typedef enum logic [2:0] {BOOT, I_ISSUE, I_WAIT, ARB, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic [7:0] retry_reg, retry_next;
  logic [7:0] tmo_reg, tmo_next;
  // One-hot {R1,R0}; 00 after reset so the first contested grant goes to R0.
  logic [1:0] last_grant_reg, last_grant_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       init_done_reg, init_done_next;
  logic       init_err_reg, init_err_next;
  logic       en_reg, en_next;
  logic       rw_reg, rw_next;
  logic [5:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [1:0] ack_reg, ack_next;
  logic [1:0] err_reg, err_next;

  logic        gnt;
  logic        resp_fail;
  logic        can_retry;
  logic        access_next;
  logic [13:0] ent;

  function automatic logic [13:0] boot_entry(input logic [1:0] i);
    case (i)
      2'd0:    boot_entry = {6'h0A, 8'h00};
      2'd1:    boot_entry = {6'h04, 8'h45};
      default: boot_entry = {6'h07, 8'h00};
    endcase
  endfunction

  always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
    if (RST_A_USB) begin
      state_reg      <= BOOT;
      idx_reg        <= '0;
      retry_reg      <= '0;
      tmo_reg        <= '0;
      last_grant_reg <= '0;
      rdata_reg      <= '0;
      init_done_reg  <= 1'b0;
      init_err_reg   <= 1'b0;
      en_reg         <= 1'b0;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ack_reg        <= '0;
      err_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      retry_reg      <= retry_next;
      tmo_reg        <= tmo_next;
      last_grant_reg <= last_grant_next;
      rdata_reg      <= rdata_next;
      init_done_reg  <= init_done_next;
      init_err_reg   <= init_err_next;
      en_reg         <= en_next;
      rw_reg         <= rw_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    retry_next      = retry_reg;
    tmo_next        = tmo_reg;
    last_grant_next = last_grant_reg;
    rdata_next      = rdata_reg;
    init_done_next  = init_done_reg;
    init_err_next   = init_err_reg;
    en_next         = 1'b0;
    rw_next         = rw_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    ack_next        = '0;
    err_next        = '0;
    gnt             = 1'b0;
    ent             = '0;
    // A timeout behaves exactly like an abort; DONE beats FAIL in the same cycle.
    resp_fail   = (U_REG_FAIL || (tmo_reg == TIMEOUT)) && !U_REG_DONE;
    can_retry   = retry_reg < MAX_R;

    if (state_reg != BOOT && !U_READY) begin
      state_next     = BOOT;
      init_done_next = 1'b0;
      retry_next     = '0;
      if (state_reg == ISSUE || state_reg == WAIT)
        err_next[last_grant_reg[1]] = 1'b1;
    end else begin
      unique case (state_reg)
        BOOT: begin
          idx_next       = '0;
          retry_next     = '0;
          init_done_next = 1'b0;
          if (U_READY) state_next = I_ISSUE;
        end
        I_ISSUE: begin
          en_next    = 1'b1;
          tmo_next   = '0;
          state_next = I_WAIT;
        end
        I_WAIT: begin
          tmo_next = tmo_reg + 8'd1;
          if (U_REG_DONE || (resp_fail && !can_retry)) begin
            retry_next = '0;
            if (!U_REG_DONE) init_err_next = 1'b1;
            if (idx_reg == 2'd2) begin
              init_done_next = 1'b1;
              state_next     = ARB;
            end else begin
              idx_next   = idx_reg + 2'd1;
              state_next = I_ISSUE;
            end
          end else if (resp_fail) begin
            retry_next = retry_reg + 8'd1;
            state_next = I_ISSUE;
          end
        end
        ARB: begin
          if (init_done_reg && (R0_REQ || R1_REQ)) begin
            gnt             = (R0_REQ && R1_REQ) ? last_grant_reg[0] : R1_REQ;
            last_grant_next = gnt ? 2'b10 : 2'b01;
            rw_next         = gnt ? R1_RW : R0_RW;
            addr_next       = gnt ? R1_ADDR : R0_ADDR;
            wdata_next      = gnt ? R1_WDATA : R0_WDATA;
            retry_next      = '0;
            state_next      = ISSUE;
          end
        end
        ISSUE: begin
          en_next    = 1'b1;
          tmo_next   = '0;
          state_next = WAIT;
        end
        WAIT: begin
          tmo_next = tmo_reg + 8'd1;
          if (U_REG_DONE) begin
            if (!rw_reg) rdata_next = U_REG_DATA_O;
            retry_next                  = '0;
            ack_next[last_grant_reg[1]] = 1'b1;
            state_next                  = RESP;
          end else if (resp_fail && !can_retry) begin
            retry_next                  = '0;
            err_next[last_grant_reg[1]] = 1'b1;
            state_next                  = RESP;
          end else if (resp_fail) begin
            retry_next = retry_reg + 8'd1;
            state_next = ISSUE;
          end
        end
        RESP:    state_next = ARB;
        default: state_next = BOOT;
      endcase
    end

    if (state_next == I_ISSUE) begin
      ent        = boot_entry(idx_next);
      rw_next    = 1'b1;
      addr_next  = ent[13:8];
      wdata_next = ent[7:0];
    end

    // Access fields are held from issue to response and zero otherwise.
    access_next = (state_next == I_ISSUE) || (state_next == I_WAIT) ||
                  (state_next == ISSUE) || (state_next == WAIT);
    if (!access_next) begin
      rw_next    = 1'b0;
      addr_next  = '0;
      wdata_next = '0;
    end
  end

  assign U_REG_EN     = en_reg;
  assign U_REG_RW     = rw_reg;
  assign U_REG_ADDR   = addr_reg;
  assign U_REG_DATA_I = wdata_reg;
  assign R0_ACK       = ack_reg[0];
  assign R1_ACK       = ack_reg[1];
  assign R0_ERR       = err_reg[0];
  assign R1_ERR       = err_reg[1];
  assign RDATA        = rdata_reg;
  assign INIT_DONE    = init_done_reg;
  assign INIT_ERR     = init_err_reg;

endmodule

// File: tb/tb_ulpi_reg_seq.sv
`timescale 1ns/1ps
// Bench for ulpi_reg_seq: PHY responder model plus a scoreboard of expected
// register-port accesses checked as each U_REG_EN strobe appears.
module tb_ulpi_reg_seq;

  logic       CLK_60M = 1'b0;
  logic       RST_A_USB = 1'b0;
  logic       U_READY = 1'b0;
  logic       U_REG_DONE, U_REG_FAIL;
  logic [7:0] U_REG_DATA_O;
  logic       U_REG_EN, U_REG_RW;
  logic [5:0] U_REG_ADDR;
  logic [7:0] U_REG_DATA_I;
  logic       R0_REQ = 1'b0, R0_RW = 1'b0, R1_REQ = 1'b0, R1_RW = 1'b0;
  logic [5:0] R0_ADDR = '0, R1_ADDR = '0;
  logic [7:0] R0_WDATA = '0, R1_WDATA = '0;
  logic       R0_ACK, R1_ACK, R0_ERR, R1_ERR;
  logic [7:0] RDATA;
  logic       INIT_DONE, INIT_ERR;

  ulpi_reg_seq #(.MAX_RETRY(3), .TIMEOUT(8'd255)) dut (
    .CLK_60M(CLK_60M), .RST_A_USB(RST_A_USB), .U_READY(U_READY),
    .U_REG_DONE(U_REG_DONE), .U_REG_FAIL(U_REG_FAIL), .U_REG_DATA_O(U_REG_DATA_O),
    .U_REG_EN(U_REG_EN), .U_REG_RW(U_REG_RW), .U_REG_ADDR(U_REG_ADDR),
    .U_REG_DATA_I(U_REG_DATA_I),
    .R0_REQ(R0_REQ), .R0_RW(R0_RW), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
    .R1_REQ(R1_REQ), .R1_RW(R1_RW), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
    .R0_ACK(R0_ACK), .R1_ACK(R1_ACK), .R0_ERR(R0_ERR), .R1_ERR(R1_ERR),
    .RDATA(RDATA), .INIT_DONE(INIT_DONE), .INIT_ERR(INIT_ERR)
  );

  always #8 CLK_60M = ~CLK_60M;

  int cyc = 0;
  always @(posedge CLK_60M) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic       id;
    logic [7:0] rdata;
    int         cyc;
  } resp_t;

  logic [14:0] exp_q[$];
  int          en_cyc_q[$];
  int          done_cyc_q[$];
  int          fail_cyc_q[$];
  resp_t       resp_log[$];

  int total = 0;
  int bad   = 0;

  int         phy_delay     = 4;
  logic       phy_silent    = 1'b0;
  logic       phy_both      = 1'b0;
  logic [5:0] phy_fail_addr = '0;
  int         phy_fail_left = 0;
  logic [7:0] phy_rdata     = '0;

  // PHY model: answers each strobe phy_delay cycles later with DONE or FAIL.
  initial begin
    logic [5:0] a;
    U_REG_DONE = 1'b0; U_REG_FAIL = 1'b0; U_REG_DATA_O = '0;
    forever begin
      @(posedge CLK_60M); #1;
      if (U_REG_EN === 1'b1 && !phy_silent) begin
        a = U_REG_ADDR;
        repeat (phy_delay) @(posedge CLK_60M);
        #1;
        if (phy_fail_left > 0 && a == phy_fail_addr) begin
          phy_fail_left--;
          U_REG_FAIL = 1'b1;
          fail_cyc_q.push_back(cyc);
        end else begin
          U_REG_DONE   = 1'b1;
          U_REG_FAIL   = phy_both;
          U_REG_DATA_O = phy_rdata;
          done_cyc_q.push_back(cyc);
        end
        @(posedge CLK_60M); #1;
        U_REG_DONE = 1'b0; U_REG_FAIL = 1'b0; U_REG_DATA_O = '0;
      end
    end
  end

  // Scoreboard: every strobe must match the next expected access in order.
  always begin
    logic [14:0] obs, e;
    @(posedge CLK_60M); #1;
    if (U_REG_EN === 1'b1) begin
      obs = {U_REG_RW, U_REG_ADDR, U_REG_DATA_I};
      en_cyc_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL en_unexpected got rw=%b addr=%h data=%h want none", obs[14], obs[13:8], obs[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL en_access got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h",
                   obs[14], obs[13:8], obs[7:0], e[14], e[13:8], e[7:0]);
        end else
          $display("en  cyc=%0d rw=%b addr=%h data=%h", cyc, obs[14], obs[13:8], obs[7:0]);
      end
    end
    if ((R0_ACK | R1_ACK | R0_ERR | R1_ERR) === 1'b1) begin
      resp_log.push_back('{err: (R0_ERR | R1_ERR), id: (R1_ACK | R1_ERR), rdata: RDATA, cyc: cyc});
      $display("rsp cyc=%0d r0_ack=%b r1_ack=%b r0_err=%b r1_err=%b rdata=%h",
               cyc, R0_ACK, R1_ACK, R0_ERR, R1_ERR, RDATA);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1);
  end

  task automatic do_reset();
    U_READY = 1'b0; R0_REQ = 1'b0; R1_REQ = 1'b0;
    #3 RST_A_USB = 1'b1;
    repeat (8) @(posedge CLK_60M);
    en_cyc_q.delete(); done_cyc_q.delete(); fail_cyc_q.delete(); resp_log.delete();
    #2 RST_A_USB = 1'b0;
    U_READY = 1'b1;
  endtask

  task automatic push_boot();
    exp_q.push_back({1'b1, 6'h0A, 8'h00});
    exp_q.push_back({1'b1, 6'h04, 8'h45});
    exp_q.push_back({1'b1, 6'h07, 8'h00});
  endtask

  task automatic wait_init(output bit ok);
    int n = 0;
    while (INIT_DONE !== 1'b1 && n < 3000) begin @(posedge CLK_60M); #2; n++; end
    ok = (INIT_DONE === 1'b1);
  endtask

  task automatic wait_resp(input int cnt, input int limit);
    int n = 0;
    while (resp_log.size() < cnt && n < limit) begin @(posedge CLK_60M); #2; n++; end
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    RST_A_USB = 1'b0; #1 RST_A_USB = 1'b1; #2;
    outs = {U_REG_EN, U_REG_RW, U_REG_ADDR, U_REG_DATA_I, R0_ACK, R1_ACK, R0_ERR, R1_ERR, RDATA, INIT_DONE, INIT_ERR};
    total++;
    if (outs !== 30'd0) begin bad++; $display("FAIL reset_async got=%h want=0", outs); end
    else $display("reset: outputs zero");
    U_READY = 1'b1;
    repeat (4) @(posedge CLK_60M); #2;
    outs = {U_REG_EN, U_REG_RW, U_REG_ADDR, U_REG_DATA_I, R0_ACK, R1_ACK, R0_ERR, R1_ERR, RDATA, INIT_DONE, INIT_ERR};
    total++;
    if (outs !== 30'd0) begin bad++; $display("FAIL reset_held got=%h want=0", outs); end
  endtask

  task automatic test_boot();
    bit ok;
    phy_delay = 4; phy_silent = 1'b0; phy_both = 1'b0; phy_fail_left = 0;
    do_reset();
    push_boot();
    wait_init(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL boot_init_done got=%b want=1", INIT_DONE); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL boot_missing got=%0d left want=0", exp_q.size()); exp_q.delete(); end
    total++;
    if (INIT_ERR !== 1'b0) begin bad++; $display("FAIL boot_init_err got=%b want=0", INIT_ERR); end
  endtask

  task automatic test_retry();
    bit ok;
    phy_fail_addr = 6'h04; phy_fail_left = 2;
    do_reset();
    exp_q.push_back({1'b1, 6'h0A, 8'h00});
    repeat (3) exp_q.push_back({1'b1, 6'h04, 8'h45});
    exp_q.push_back({1'b1, 6'h07, 8'h00});
    wait_init(ok);
    total++;
    if (!ok || exp_q.size() != 0 || INIT_ERR !== 1'b0) begin
      bad++;
      $display("FAIL retry2 got done=%b left=%0d init_err=%b want 1/0/0", INIT_DONE, exp_q.size(), INIT_ERR);
      exp_q.delete();
    end
    total++;
    if (en_cyc_q.size() < 4 || fail_cyc_q.size() < 2) begin
      bad++; $display("FAIL retry_gap_count got en=%0d fail=%0d want 5/2", en_cyc_q.size(), fail_cyc_q.size());
    end else if (en_cyc_q[2] - fail_cyc_q[0] != 2 || en_cyc_q[3] - fail_cyc_q[1] != 2) begin
      bad++;
      $display("FAIL retry_gap got %0d,%0d want 2,2", en_cyc_q[2] - fail_cyc_q[0], en_cyc_q[3] - fail_cyc_q[1]);
    end

    phy_fail_left = 4;
    do_reset();
    exp_q.push_back({1'b1, 6'h0A, 8'h00});
    repeat (4) exp_q.push_back({1'b1, 6'h04, 8'h45});
    exp_q.push_back({1'b1, 6'h07, 8'h00});
    wait_init(ok);
    total++;
    if (!ok || exp_q.size() != 0 || INIT_ERR !== 1'b1) begin
      bad++;
      $display("FAIL retry_exhaust got done=%b left=%0d init_err=%b want 1/0/1", INIT_DONE, exp_q.size(), INIT_ERR);
      exp_q.delete();
    end
    phy_fail_left = 0;
  endtask

  task automatic test_arb();
    bit ok;
    logic want_id;
    do_reset();
    push_boot();
    wait_init(ok);
    total++;
    if (!ok || INIT_ERR !== 1'b0) begin bad++; $display("FAIL arb_boot got done=%b err=%b want 1/0", INIT_DONE, INIT_ERR); end
    done_cyc_q.delete(); resp_log.delete();
    R0_RW = 1'b1; R0_ADDR = 6'h11; R0_WDATA = 8'hA0;
    R1_RW = 1'b1; R1_ADDR = 6'h22; R1_WDATA = 8'hB1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 6'h11, 8'hA0});
      exp_q.push_back({1'b1, 6'h22, 8'hB1});
    end
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    wait_resp(4, 400);
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    total++;
    if (resp_log.size() != 4) begin bad++; $display("FAIL arb_resp_count got=%0d want=4", resp_log.size()); end
    for (int i = 0; i < 4 && i < resp_log.size(); i++) begin
      want_id = (i % 2) == 1;
      total++;
      if (resp_log[i].err !== 1'b0 || resp_log[i].id !== want_id || i >= done_cyc_q.size()) begin
        bad++;
        $display("FAIL arb_order[%0d] got id=%b err=%b want id=%b err=0", i, resp_log[i].id, resp_log[i].err, want_id);
      end else if (resp_log[i].cyc != done_cyc_q[i] + 1) begin
        bad++;
        $display("FAIL arb_ack_latency[%0d] got=%0d want=%0d", i, resp_log[i].cyc, done_cyc_q[i] + 1);
      end
    end
    repeat (20) @(posedge CLK_60M); #2;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL arb_missing got=%0d left want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_read_timeout();
    int gap;
    resp_log.delete(); done_cyc_q.delete();
    R1_RW = 1'b0; R1_ADDR = 6'h00; R1_WDATA = 8'h00;
    phy_rdata = 8'h24; phy_both = 1'b1;
    exp_q.push_back({1'b0, 6'h00, 8'h00});
    R1_REQ = 1'b1;
    wait_resp(1, 200);
    R1_REQ = 1'b0; phy_both = 1'b0;
    total++;
    if (resp_log.size() < 1 || done_cyc_q.size() < 1) begin
      bad++; $display("FAIL read_no_resp got=%0d want=1", resp_log.size());
    end else if (resp_log[0].err !== 1'b0 || resp_log[0].id !== 1'b1 || resp_log[0].rdata !== 8'h24
                 || resp_log[0].cyc != done_cyc_q[0] + 1) begin
      bad++;
      $display("FAIL read_ack got id=%b err=%b rdata=%h cyc=%0d want id=1 err=0 rdata=24 cyc=%0d",
               resp_log[0].id, resp_log[0].err, resp_log[0].rdata, resp_log[0].cyc, done_cyc_q[0] + 1);
    end

    repeat (3) @(posedge CLK_60M); #2;
    resp_log.delete(); en_cyc_q.delete();
    phy_silent = 1'b1;
    R1_ADDR = 6'h05;
    repeat (4) exp_q.push_back({1'b0, 6'h05, 8'h00});
    R1_REQ = 1'b1;
    wait_resp(1, 1500);
    R1_REQ = 1'b0;
    total++;
    if (resp_log.size() < 1 || en_cyc_q.size() < 1) begin
      bad++; $display("FAIL timeout_no_err got=%0d want=1", resp_log.size());
    end else begin
      gap = resp_log[0].cyc - en_cyc_q[0];
      if (resp_log[0].err !== 1'b1 || resp_log[0].id !== 1'b1 || gap < 1024 || gap > 1032) begin
        bad++;
        $display("FAIL timeout_err got id=%b err=%b gap=%0d want id=1 err=1 gap=1024..1032",
                 resp_log[0].id, resp_log[0].err, gap);
      end
    end
    total++;
    if (exp_q.size() != 0 || RDATA !== 8'h24) begin
      bad++; $display("FAIL timeout_tail got left=%0d rdata=%h want 0/24", exp_q.size(), RDATA);
      exp_q.delete();
    end
    phy_silent = 1'b0;
  endtask

  task automatic test_link_loss();
    bit ok;
    int n = 0;
    resp_log.delete();
    phy_silent = 1'b1;
    R0_RW = 1'b1; R0_ADDR = 6'h15; R0_WDATA = 8'h5A;
    exp_q.push_back({1'b1, 6'h15, 8'h5A});
    R0_REQ = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin @(posedge CLK_60M); #2; n++; end
    repeat (3) @(posedge CLK_60M); #2;
    U_READY = 1'b0;
    @(posedge CLK_60M); #2;
    total++;
    if (R0_ERR !== 1'b1 || R1_ERR !== 1'b0 || INIT_DONE !== 1'b0 || U_REG_ADDR !== 6'h00) begin
      bad++;
      $display("FAIL link_loss got r0_err=%b r1_err=%b init_done=%b addr=%h want 1/0/0/00",
               R0_ERR, R1_ERR, INIT_DONE, U_REG_ADDR);
    end
    R0_REQ = 1'b0;
    @(posedge CLK_60M); #2;
    total++;
    if (R0_ERR !== 1'b0) begin bad++; $display("FAIL link_err_pulse got=%b want=0", R0_ERR); end
    phy_silent = 1'b0;
    push_boot();
    U_READY = 1'b1;
    wait_init(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++; $display("FAIL link_reboot got done=%b left=%0d want 1/0", INIT_DONE, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    logic [29:0] outs;
    int n = 0;
    phy_silent = 1'b1;
    R0_RW = 1'b1; R0_ADDR = 6'h16; R0_WDATA = 8'h33;
    exp_q.push_back({1'b1, 6'h16, 8'h33});
    R0_REQ = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin @(posedge CLK_60M); #2; n++; end
    repeat (2) @(posedge CLK_60M);
    #4 RST_A_USB = 1'b1;
    #1;
    outs = {U_REG_EN, U_REG_RW, U_REG_ADDR, U_REG_DATA_I, R0_ACK, R1_ACK, R0_ERR, R1_ERR, RDATA, INIT_DONE, INIT_ERR};
    total++;
    if (outs !== 30'd0) begin bad++; $display("FAIL reset_mid_wait got=%h want=0", outs); end
    R0_REQ = 1'b0;
    repeat (4) @(posedge CLK_60M);
    phy_silent = 1'b0;
    push_boot();
    #2 RST_A_USB = 1'b0;
    wait_init(ok);
    total++;
    if (!ok || exp_q.size() != 0 || INIT_ERR !== 1'b0) begin
      bad++; $display("FAIL reset_reboot got done=%b left=%0d err=%b want 1/0/0", INIT_DONE, exp_q.size(), INIT_ERR);
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_retry();
    test_arb();
    test_read_timeout();
    test_link_loss();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
